// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: circular receive buffer that sits behind the UART receiver.
// It captures a byte on each receiver done pulse and holds it until the host
// reads it. It reports the fill level, the full/empty/almost-full flags and a
// sticky overflow flag.
// Optional build macro: UART_RX_FIFO_DROP_CNT_EN adds a saturating 8-bit
// counter of dropped bytes. When the macro is not defined, drop_cnt reads 0.
module uart_rx_fifo #(
    parameter int DW    = 8,
    parameter int AW    = 4,
    parameter int AF_TH = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_tick,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          empty,
    output logic          full,
    output logic          almost_full,
    output logic [AW:0]   count,
    output logic          overflow,
    input  logic          ovf_clr,
    output logic [7:0]    drop_cnt
);

    localparam int          DEPTH    = 1 << AW;
    localparam logic [AW:0] DEPTH_L  = (AW+1)'(DEPTH);
    localparam logic [AW:0] LAST_L   = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] ONE_L    = (AW+1)'(1);
    localparam logic [AW:0] AF_L     = (AW+1)'(AF_TH);

    typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} state_t;

    logic [DW-1:0] mem [DEPTH];

    state_t        state_reg, state_next;
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg, count_next;
    logic [DW-1:0] rd_data_reg;
    logic          rd_valid_reg;
    logic          overflow_reg, overflow_next;

    logic          wr_accept, rd_accept, drop;

    // The occupancy FSM gates the accepts. A read frees the slot that a
    // write made in the same cycle into a full FIFO needs. There is no bypass
    // when the FIFO is empty.
    assign rd_accept = rd_en & (state_reg != ST_EMPTY);
    assign wr_accept = wr_tick & ((state_reg != ST_FULL) | rd_accept);
    assign drop      = wr_tick & ~wr_accept;

    assign empty       = (count_reg == '0);
    assign full        = (count_reg == DEPTH_L);
    assign almost_full = (count_reg >= AF_L);
    assign count       = count_reg;
    assign rd_data     = rd_data_reg;
    assign rd_valid    = rd_valid_reg;
    assign overflow    = overflow_reg;

    // Next-state for the occupancy FSM, the level counter and the sticky overflow flag.
    always_comb begin
        state_next    = state_reg;
        count_next    = count_reg;
        overflow_next = overflow_reg;

        case ({wr_accept, rd_accept})
            2'b10:   count_next = count_reg + ONE_L;
            2'b01:   count_next = count_reg - ONE_L;
            default: count_next = count_reg;
        endcase

        case (state_reg)
            ST_EMPTY: begin
                if (wr_accept) state_next = ST_PARTIAL;
            end
            ST_PARTIAL: begin
                if (rd_accept && !wr_accept && count_reg == ONE_L)
                    state_next = ST_EMPTY;
                else if (wr_accept && !rd_accept && count_reg == LAST_L)
                    state_next = ST_FULL;
            end
            ST_FULL: begin
                if (rd_accept && !wr_accept) state_next = ST_PARTIAL;
            end
            default: state_next = ST_EMPTY;
        endcase

        // A drop in the same cycle as a clear leaves the flag set.
        if (drop)
            overflow_next = 1'b1;
        else if (ovf_clr)
            overflow_next = 1'b0;
    end

    // Control and status registers. Reset throws away every stored entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_EMPTY;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
            rd_valid_reg <= rd_accept;
            if (wr_accept) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (rd_accept) begin
                rd_ptr_reg  <= rd_ptr_reg + AW'(1);
                rd_data_reg <= mem[rd_ptr_reg];
            end
        end
    end

    // Storage array. It has no reset, so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_accept) mem[wr_ptr_reg] <= wr_data;
    end

`ifdef UART_RX_FIFO_DROP_CNT_EN
    logic [7:0] drop_cnt_reg, drop_cnt_next;

    // Saturating count of dropped bytes. A drop in the same cycle as a clear restarts the count at 1.
    always_comb begin
        drop_cnt_next = drop_cnt_reg;
        if (drop && ovf_clr)
            drop_cnt_next = 8'd1;
        else if (drop)
            drop_cnt_next = (drop_cnt_reg == 8'hFF) ? 8'hFF : drop_cnt_reg + 8'd1;
        else if (ovf_clr)
            drop_cnt_next = 8'd0;
    end

    // Drop counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_cnt_reg <= 8'd0;
        else        drop_cnt_reg <= drop_cnt_next;
    end

    assign drop_cnt = drop_cnt_reg;
`else
    assign drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed tests for uart_rx_fifo. The expected values are worked out by hand.
module tb_uart_rx_fifo;

`ifdef UART_RX_FIFO_DROP_CNT_EN
    localparam bit DC_EN = 1'b1;
`else
    localparam bit DC_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       wr_tick;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic [4:0] count;
    logic       overflow;
    logic       ovf_clr;
    logic [7:0] drop_cnt;

    int n_cmp = 0;
    int n_err = 0;

    uart_rx_fifo #(.DW(8), .AW(4), .AF_TH(12)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_tick     (wr_tick),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr),
        .drop_cnt    (drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change 1 ns after a rising edge, and outputs are sampled at that same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] d);
        wr_tick = 1'b1;
        wr_data = d;
        step();
        wr_tick = 1'b0;
        $display("wr  data=%02h count=%0d full=%0b af=%0b ovf=%0b", d, count, full, almost_full, overflow);
    endtask

    task automatic do_read();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        $display("rd  valid=%0b data=%02h count=%0d empty=%0b", rd_valid, rd_data, count, empty);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_tick = 1'b0; wr_data = 8'h00; rd_en = 1'b0; ovf_clr = 1'b0;
        #12;
        n_cmp++; if (count !== 5'd0)    begin n_err++; $display("FAIL rst_count got=%0d exp=0", count); end
        n_cmp++; if (empty !== 1'b1)    begin n_err++; $display("FAIL rst_empty got=%0b exp=1", empty); end
        n_cmp++; if (full !== 1'b0)     begin n_err++; $display("FAIL rst_full got=%0b exp=0", full); end
        n_cmp++; if (almost_full !== 1'b0) begin n_err++; $display("FAIL rst_af got=%0b exp=0", almost_full); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_ovf got=%0b exp=0", overflow); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL rst_rdv got=%0b exp=0", rd_valid); end
        n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL rst_rdd got=%02h exp=00", rd_data); end
        n_cmp++; if (drop_cnt !== 8'h00) begin n_err++; $display("FAIL rst_dcnt got=%0d exp=0", drop_cnt); end
        rst_n = 1'b1;
        step();
        // Reset while the FIFO is half full and a read result is still on the outputs.
        for (int i = 0; i < 9; i++) do_write(8'h80 + 8'(i));
        do_read();
        n_cmp++; if (count !== 5'd8 || rd_valid !== 1'b1) begin n_err++; $display("FAIL pre_rst got count=%0d rdv=%0b exp 8/1", count, rd_valid); end
        #2 rst_n = 1'b0;
        #1;
        $display("rst mid-cycle count=%0d empty=%0b", count, empty);
        n_cmp++; if (count !== 5'd0)    begin n_err++; $display("FAIL mid_rst_count got=%0d exp=0", count); end
        n_cmp++; if (empty !== 1'b1)    begin n_err++; $display("FAIL mid_rst_empty got=%0b exp=1", empty); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL mid_rst_ovf got=%0b exp=0", overflow); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_rdv got=%0b exp=0", rd_valid); end
        n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL mid_rst_rdd got=%02h exp=00", rd_data); end
        #1 rst_n = 1'b1;
        step();
        // Entries written before the reset must not come back out.
        do_read();
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_rd got rdv=%0b exp=0", rd_valid); end
    endtask

    task automatic test_basic();
        do_write(8'h55);
        do_write(8'hA3);
        n_cmp++; if (count !== 5'd2) begin n_err++; $display("FAIL basic_count got=%0d exp=2", count); end
        do_read();
        n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 8'h55) begin n_err++; $display("FAIL basic_rd0 got v=%0b d=%02h exp 1/55", rd_valid, rd_data); end
        do_read();
        n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 8'hA3) begin n_err++; $display("FAIL basic_rd1 got v=%0b d=%02h exp 1/a3", rd_valid, rd_data); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL basic_empty got=%0b exp=1", empty); end
        step();
        n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL basic_pulse got=%0b exp=0", rd_valid); end
        do_read();
        n_cmp++; if (rd_valid !== 1'b0 || rd_data !== 8'hA3 || count !== 5'd0) begin n_err++; $display("FAIL basic_rd_empty got v=%0b d=%02h c=%0d exp 0/a3/0", rd_valid, rd_data, count); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            do_write(8'(i));
            n_cmp++; if (almost_full !== (i >= 11)) begin n_err++; $display("FAIL fill_af%0d got=%0b exp=%0b", i, almost_full, (i >= 11)); end
            n_cmp++; if (full !== (i == 15)) begin n_err++; $display("FAIL fill_full%0d got=%0b exp=%0b", i, full, (i == 15)); end
        end
        do_write(8'hFF);
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL fill_ovf got=%0b exp=1", overflow); end
        n_cmp++; if (count !== 5'd16)   begin n_err++; $display("FAIL fill_count got=%0d exp=16", count); end
        n_cmp++; if (drop_cnt !== (DC_EN ? 8'd1 : 8'd0)) begin n_err++; $display("FAIL fill_dcnt got=%0d exp=%0d", drop_cnt, DC_EN); end
        for (int i = 0; i < 16; i++) begin
            do_read();
            n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin n_err++; $display("FAIL fill_rd%0d got v=%0b d=%02h exp 1/%02h", i, rd_valid, rd_data, i); end
        end
        n_cmp++; if (empty !== 1'b1 || overflow !== 1'b1) begin n_err++; $display("FAIL fill_end got e=%0b o=%0b exp 1/1", empty, overflow); end
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        n_cmp++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin n_err++; $display("FAIL fill_clr got o=%0b dc=%0d exp 0/0", overflow, drop_cnt); end
    endtask

    task automatic test_full_simul();
        for (int i = 0; i < 16; i++) do_write(8'h20 + 8'(i));
        wr_tick = 1'b1; wr_data = 8'hC7; rd_en = 1'b1;
        step();
        wr_tick = 1'b0; rd_en = 1'b0;
        $display("wr+rd full: valid=%0b data=%02h count=%0d ovf=%0b", rd_valid, rd_data, count, overflow);
        n_cmp++; if (count !== 5'd16 || overflow !== 1'b0) begin n_err++; $display("FAIL fsim_state got c=%0d o=%0b exp 16/0", count, overflow); end
        n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 8'h20) begin n_err++; $display("FAIL fsim_rd got v=%0b d=%02h exp 1/20", rd_valid, rd_data); end
        for (int i = 1; i < 16; i++) begin
            do_read();
            n_cmp++; if (rd_data !== 8'h20 + 8'(i)) begin n_err++; $display("FAIL fsim_rd%0d got=%02h exp=%02h", i, rd_data, 8'h20 + 8'(i)); end
        end
        do_read();
        n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 8'hC7 || empty !== 1'b1) begin n_err++; $display("FAIL fsim_last got v=%0b d=%02h e=%0b exp 1/c7/1", rd_valid, rd_data, empty); end
    endtask

    task automatic test_empty_simul();
        wr_tick = 1'b1; wr_data = 8'h3C; rd_en = 1'b1;
        step();
        wr_tick = 1'b0; rd_en = 1'b0;
        $display("wr+rd empty: valid=%0b count=%0d", rd_valid, count);
        n_cmp++; if (rd_valid !== 1'b0 || count !== 5'd1) begin n_err++; $display("FAIL esim got v=%0b c=%0d exp 0/1", rd_valid, count); end
        do_read();
        n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 8'h3C || empty !== 1'b1) begin n_err++; $display("FAIL esim_rd got v=%0b d=%02h e=%0b exp 1/3c/1", rd_valid, rd_data, empty); end
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 20; k++) begin
            for (int j = 0; j < 10; j++) do_write(8'(k * 10 + j));
            for (int j = 0; j < 10; j++) begin
                do_read();
                n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 8'(k * 10 + j)) begin n_err++; $display("FAIL wrap%0d_%0d got v=%0b d=%02h exp 1/%02h", k, j, rd_valid, rd_data, 8'(k * 10 + j)); end
            end
        end
        for (int i = 0; i < 16; i++) do_write(8'(i));
        do_write(8'hEE);
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL wrap_ovf got=%0b exp=1", overflow); end
        wr_tick = 1'b1; wr_data = 8'hEF; ovf_clr = 1'b1;
        step();
        wr_tick = 1'b0; ovf_clr = 1'b0;
        $display("drop+clr: ovf=%0b dcnt=%0d count=%0d", overflow, drop_cnt, count);
        n_cmp++; if (overflow !== 1'b1 || count !== 5'd16) begin n_err++; $display("FAIL dropclr got o=%0b c=%0d exp 1/16", overflow, count); end
        n_cmp++; if (drop_cnt !== (DC_EN ? 8'd1 : 8'd0)) begin n_err++; $display("FAIL dropclr_dcnt got=%0d exp=%0d", drop_cnt, DC_EN); end
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        n_cmp++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin n_err++; $display("FAIL clr got o=%0b dc=%0d exp 0/0", overflow, drop_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_full_simul();
        test_empty_simul();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout compared=%0d limit=500000ns", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
